// File: rtl/t_chg_chain.sv
`default_nettype none
// ============================================================================
// Module  : t_chg_chain
// Brief   : Chain of +1 stages (combinational or registered) with an FSM that
//           drives seeds through it and checks each result against seed+STAGES.
// Revision: 1.0 - initial release
// ============================================================================
module t_chg_chain #(
    parameter int               WIDTH      = 32,
    parameter int               STAGES     = 4,
    parameter int               REGISTERED = 0,
    parameter int               NUM_SEEDS  = 3,
    parameter logic [WIDTH-1:0] SEED0      = 'd1,
    parameter logic [WIDTH-1:0] SEED_STEP  = 'd16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             inject_err,
    output logic             busy,
    output logic             passed,
    output logic             failed,
    output logic [WIDTH-1:0] chain_out,
    output logic [7:0]       iter
);

    localparam int c_LAT    = (REGISTERED != 0) ? STAGES : 1;
    localparam int c_WCNT_W = $clog2(c_LAT + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [WIDTH-1:0]    r_seed, w_seed_nxt;
    logic [7:0]          r_iter, w_iter_nxt;
    logic [c_WCNT_W-1:0] r_wcnt, w_wcnt_nxt;
    logic                r_passed, w_passed_nxt;
    logic                r_failed, w_failed_nxt;
    logic [WIDTH-1:0]    w_exp;

    logic [WIDTH-1:0] w_stage_in  [STAGES];
    logic [WIDTH-1:0] w_stage_out [STAGES];

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stage
            logic [WIDTH-1:0] w_sum;

            if (k == 0) begin : g_first
                assign w_stage_in[k] = r_seed;
            end else begin : g_next
                assign w_stage_in[k] = w_stage_out[k-1];
            end

            // Only the final stage can be forced to mis-add, so the fault
            // shows up exactly once in the chain result.
            if (k == STAGES - 1) begin : g_last
                assign w_sum = w_stage_in[k] + (inject_err ? WIDTH'(2) : WIDTH'(1));
            end else begin : g_mid
                assign w_sum = w_stage_in[k] + WIDTH'(1);
            end

            if (REGISTERED != 0) begin : g_reg
                logic [WIDTH-1:0] r_q;
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) r_q <= '0;
                    else        r_q <= w_sum;
                end
                assign w_stage_out[k] = r_q;
            end else begin : g_comb
                assign w_stage_out[k] = w_sum;
            end
        end
    endgenerate

    assign chain_out = w_stage_out[STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_seed   <= '0;
            r_iter   <= '0;
            r_wcnt   <= '0;
            r_passed <= 1'b0;
            r_failed <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_seed   <= w_seed_nxt;
            r_iter   <= w_iter_nxt;
            r_wcnt   <= w_wcnt_nxt;
            r_passed <= w_passed_nxt;
            r_failed <= w_failed_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_seed_nxt   = r_seed;
        w_iter_nxt   = r_iter;
        w_wcnt_nxt   = r_wcnt;
        w_passed_nxt = r_passed;
        w_failed_nxt = r_failed;
        w_exp        = r_seed + WIDTH'(STAGES);
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_seed_nxt   = SEED0;
                    w_iter_nxt   = '0;
                    w_wcnt_nxt   = c_WCNT_W'(c_LAT);
                    w_passed_nxt = 1'b0;
                    w_failed_nxt = 1'b0;
                    w_state_nxt  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                w_wcnt_nxt = r_wcnt - c_WCNT_W'(1);
                if (r_wcnt == c_WCNT_W'(1)) w_state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                if (chain_out != w_exp) begin
                    w_failed_nxt = 1'b1;
                    w_state_nxt  = ST_DONE;
                end else if (r_iter == 8'(NUM_SEEDS - 1)) begin
                    w_passed_nxt = 1'b1;
                    w_state_nxt  = ST_DONE;
                end else begin
                    w_iter_nxt  = r_iter + 8'd1;
                    w_seed_nxt  = r_seed + SEED_STEP;
                    w_wcnt_nxt  = c_WCNT_W'(c_LAT);
                    w_state_nxt = ST_WAIT;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign busy   = (r_state == ST_WAIT) || (r_state == ST_CHECK);
    assign passed = r_passed;
    assign failed = r_failed;
    assign iter   = r_iter;

endmodule
`default_nettype wire

// File: tb/tb_t_chg_chain.sv
`default_nettype none
// ============================================================================
// Module  : tb_t_chg_chain
// Brief   : Drives three t_chg_chain configurations and checks chain results,
//           pass/fail timing, wrap-around, error injection and reset behaviour.
// Revision: 1.0 - initial release
// ============================================================================
module tb_t_chg_chain;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  rst_n, start, inject_err;
    logic [2:0]  busy, passed, failed;
    logic [31:0] out_c, out_r;
    logic [7:0]  out_w;
    logic [7:0]  iter_c, iter_r, iter_w;

    t_chg_chain #(.WIDTH(32), .STAGES(4), .REGISTERED(0), .NUM_SEEDS(3),
                  .SEED0(32'd1), .SEED_STEP(32'd16)) u_comb (
        .clk(clk), .rst_n(rst_n[0]), .start(start[0]), .inject_err(inject_err[0]),
        .busy(busy[0]), .passed(passed[0]), .failed(failed[0]),
        .chain_out(out_c), .iter(iter_c));

    t_chg_chain #(.WIDTH(32), .STAGES(4), .REGISTERED(1), .NUM_SEEDS(3),
                  .SEED0(32'd1), .SEED_STEP(32'd16)) u_reg (
        .clk(clk), .rst_n(rst_n[1]), .start(start[1]), .inject_err(inject_err[1]),
        .busy(busy[1]), .passed(passed[1]), .failed(failed[1]),
        .chain_out(out_r), .iter(iter_r));

    t_chg_chain #(.WIDTH(8), .STAGES(4), .REGISTERED(0), .NUM_SEEDS(1),
                  .SEED0(8'hFE), .SEED_STEP(8'd16)) u_w8 (
        .clk(clk), .rst_n(rst_n[2]), .start(start[2]), .inject_err(inject_err[2]),
        .busy(busy[2]), .passed(passed[2]), .failed(failed[2]),
        .chain_out(out_w), .iter(iter_w));

    // Configuration table mirroring the three instances above
    int cfg_lat    [3] = '{1, 4, 1};
    int cfg_nseeds [3] = '{3, 3, 1};
    int cfg_seed0  [3] = '{1, 1, 254};
    int cfg_width  [3] = '{32, 32, 8};
    int cfg_rstout [3] = '{4, 0, 4};
    localparam int c_STAGES = 4;
    localparam int c_STEP   = 16;

    int          sel = 0;
    logic [31:0] obs_chain;
    logic [7:0]  obs_iter;
    logic        obs_busy, obs_passed, obs_failed;

    always_comb begin
        obs_busy   = busy[sel];
        obs_passed = passed[sel];
        obs_failed = failed[sel];
        case (sel)
            0:       begin obs_chain = out_c;          obs_iter = iter_c; end
            1:       begin obs_chain = out_r;          obs_iter = iter_r; end
            default: begin obs_chain = {24'd0, out_w}; obs_iter = iter_w; end
        endcase
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (dut %0d): got 0x%0h, expected 0x%0h", tag, sel, got, exp);
        end
    endtask

    // Expected chain result for seed k: arithmetic on the seed sequence, masked to WIDTH
    function automatic logic [31:0] model_out(input int s, input int k, input bit inj);
        longint v;
        longint mask;
        v    = longint'(cfg_seed0[s]) + longint'(k) * c_STEP + c_STAGES + (inj ? 1 : 0);
        mask = (longint'(1) << cfg_width[s]) - 1;
        return 32'(v & mask);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input int s);
        check_eq("rst_busy",   obs_busy,   0);
        check_eq("rst_passed", obs_passed, 0);
        check_eq("rst_failed", obs_failed, 0);
        check_eq("rst_iter",   obs_iter,   0);
        check_eq("rst_chain",  obs_chain,  cfg_rstout[s]);
    endtask

    // One full run. e counts edges after the start edge; we sit 1 time unit past edge e.
    task automatic run_test(input int s, input bit inj, input bit hold, input bit pre);
        int e;
        int n_total;
        sel = s;
        if (!pre) begin
            inject_err[s] = inj;
            start[s]      = 1'b1;
            tick();
        end
        if (!hold) start[s] = 1'b0;
        e       = 0;
        n_total = inj ? cfg_lat[s] + 1 : cfg_nseeds[s] * (cfg_lat[s] + 1);
        for (int k = 0; k < cfg_nseeds[s]; k++) begin
            while (e < k * (cfg_lat[s] + 1) + cfg_lat[s]) begin
                check_eq("busy_run",   obs_busy,   1);
                check_eq("passed_early", obs_passed, 0);
                tick();
                e++;
            end
            check_eq("chain_out", obs_chain, model_out(s, k, inj));
            check_eq("iter_run",  obs_iter,  k);
            if (inj) break;
        end
        while (e < n_total) begin
            check_eq("busy_run",     obs_busy,   1);
            check_eq("passed_early", obs_passed, 0);
            tick();
            e++;
        end
        check_eq("passed_end", obs_passed, !inj);
        check_eq("failed_end", obs_failed, inj);
        check_eq("busy_end",   obs_busy,   0);
        check_eq("iter_end",   obs_iter,   inj ? 0 : cfg_nseeds[s] - 1);
        inject_err[s] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n      = '0;
        start      = '0;
        inject_err = '0;
        repeat (2) tick();
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            check_reset_state(s);
        end
        rst_n = '1;
        tick();

        run_test(0, 1'b0, 1'b0, 1'b0);   // combinational, 3 seeds
        run_test(1, 1'b0, 1'b0, 1'b0);   // registered, 15-cycle run
        run_test(2, 1'b0, 1'b0, 1'b0);   // 8-bit wrap-around
        run_test(1, 1'b1, 1'b0, 1'b0);   // injected error on registered chain

        // Reset pulse during the WAIT phase of the second seed
        sel      = 1;
        start[1] = 1'b1;
        tick();
        start[1] = 1'b0;
        repeat (cfg_lat[1] + 2) tick();
        check_eq("mid_iter", obs_iter, 1);
        check_eq("mid_busy", obs_busy, 1);
        rst_n[1] = 1'b0;
        #1;
        check_reset_state(1);
        tick();
        rst_n[1] = 1'b1;
        repeat (3) tick();
        check_eq("idle_after_rst", obs_busy, 0);
        run_test(1, 1'b0, 1'b0, 1'b0);

        // Start held high across a whole run: restart on the edge after DONE
        run_test(0, 1'b0, 1'b1, 1'b0);
        tick();
        check_eq("restart_passed_clr", obs_passed, 0);
        check_eq("restart_busy",       obs_busy,   1);
        run_test(0, 1'b0, 1'b0, 1'b1);

        for (int r = 0; r < 8; r++) begin
            int  s;
            bit  inj;
            int  gap;
            s   = $urandom_range(0, 2);
            inj = ($urandom_range(0, 3) == 0);
            gap = $urandom_range(0, 4);
            repeat (gap) tick();
            run_test(s, inj, 1'b0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
